// File: rtl/result_dump.sv
// Snapshots NUM_CH result words when the core signals done, then streams them out over valid/ready.
// Optional: define RESULT_DUMP_CYCLES_EN to append the saturating run-cycle count as a final word.
module result_dump #(
   parameter  int NUM_CH = 4,
   parameter  int WIDTH  = 12,
   parameter  int CNT_W  = 16,
   localparam int IDX_W  = $clog2(NUM_CH + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    done,
   input  logic [NUM_CH*WIDTH-1:0] res_bus,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [IDX_W-1:0]        out_idx,
   output logic                    out_last,
   output logic                    busy,
   output logic                    dump_done
);

`ifdef RESULT_DUMP_CYCLES_EN
   localparam int N_W = NUM_CH + 1;
`else
   localparam int N_W = NUM_CH;
`endif

   typedef enum logic [1:0] {IDLE, RUN, STREAM} state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] snap_reg [NUM_CH];
   logic [IDX_W-1:0] next_idx;
   logic [WIDTH-1:0] next_word;
   logic             capture;

   assign capture  = (state_reg == RUN) && done;
   assign next_idx = out_idx + IDX_W'(1);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_snap
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               snap_reg[gi] <= '0;
            else if (capture)
               snap_reg[gi] <= res_bus[gi*WIDTH +: WIDTH];
         end
      end
   endgenerate

`ifdef RESULT_DUMP_CYCLES_EN
   logic [CNT_W-1:0] cnt_reg;
   logic [WIDTH-1:0] cyc_word;

   assign cyc_word = WIDTH'(cnt_reg);

   // done outranks start in RUN, so the capture cycle itself is still counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_reg <= '0;
      else if (state_reg == IDLE && start)
         cnt_reg <= '0;
      else if (state_reg == RUN) begin
         if (start && !done)
            cnt_reg <= '0;
         else if (cnt_reg != '1)
            cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end
`endif

   always_comb begin
      next_word = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (next_idx == IDX_W'(i))
            next_word = snap_reg[i];
`ifdef RESULT_DUMP_CYCLES_EN
      if (next_idx == IDX_W'(NUM_CH))
         next_word = cyc_word;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         dump_done <= 1'b0;
      end else begin
         dump_done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg <= RUN;
                  busy      <= 1'b1;
               end
            end
            RUN: begin
               // Word 0 comes straight off the bus so it is valid the cycle after capture.
               if (done) begin
                  state_reg <= STREAM;
                  out_valid <= 1'b1;
                  out_data  <= res_bus[WIDTH-1:0];
                  out_idx   <= '0;
                  out_last  <= (N_W == 1);
               end
            end
            STREAM: begin
               if (out_ready) begin
                  if (out_last) begin
                     state_reg <= IDLE;
                     busy      <= 1'b0;
                     out_valid <= 1'b0;
                     out_data  <= '0;
                     out_idx   <= '0;
                     out_last  <= 1'b0;
                     dump_done <= 1'b1;
                  end else begin
                     out_data <= next_word;
                     out_idx  <= next_idx;
                     out_last <= (next_idx == IDX_W'(N_W - 1));
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_result_dump.sv
// Scoreboard bench for result_dump: expected words are queued when done is driven and
// popped by a negedge monitor on every handshake.
module tb_result_dump;
   localparam int NUM_CH = 4;
   localparam int WIDTH  = 12;
   localparam int CNT_W  = 4;
   localparam int IDX_W  = $clog2(NUM_CH + 1);
   localparam int BUS_W  = NUM_CH * WIDTH;
`ifdef RESULT_DUMP_CYCLES_EN
   localparam int N_W = NUM_CH + 1;
`else
   localparam int N_W = NUM_CH;
`endif

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [IDX_W-1:0] idx;
      logic             last;
   } word_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic             done;
   logic [BUS_W-1:0] res_bus;
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;
   logic             busy;
   logic             dump_done;

   word_t sb[$];
   int    n_cmp   = 0;
   int    n_err   = 0;
   int    n_dumps = 0;

   result_dump #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .done(done), .res_bus(res_bus),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last), .busy(busy), .dump_done(dump_done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_valid"}, 32'(out_valid), 0);
      check_eq({tag, "_data"},  32'(out_data),  0);
      check_eq({tag, "_idx"},   32'(out_idx),   0);
      check_eq({tag, "_last"},  32'(out_last),  0);
      check_eq({tag, "_busy"},  32'(busy),      0);
      check_eq({tag, "_dd"},    32'(dump_done), 0);
   endtask

   task automatic monitor();
      bit               pend_last = 0;
      bit               hold = 0;
      logic [WIDTH-1:0] hd;
      logic [IDX_W-1:0] hi;
      logic             hl;
      word_t            e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend_last = 0;
            hold      = 0;
         end else begin
            if (pend_last || dump_done) begin
               check_eq("dump_done", 32'(dump_done), 32'(pend_last));
               if (pend_last) check_eq("busy_after_dump", 32'(busy), 0);
               if (dump_done) n_dumps++;
            end
            pend_last = 0;
            if (hold) begin
               check_eq("hold_valid", 32'(out_valid), 1);
               check_eq("hold_data",  32'(out_data),  32'(hd));
               check_eq("hold_idx",   32'(out_idx),   32'(hi));
               check_eq("hold_last",  32'(out_last),  32'(hl));
            end
            hold = out_valid && !out_ready;
            hd = out_data; hi = out_idx; hl = out_last;
            if (out_valid && out_ready) begin
               check_eq("sb_nonempty", 32'(sb.size() != 0), 1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  $display("word idx=%0d data=%03h last=%0b (exp idx=%0d data=%03h last=%0b)",
                           out_idx, out_data, out_last, e.idx, e.data, e.last);
                  check_eq("word_data", 32'(out_data), 32'(e.data));
                  check_eq("word_idx",  32'(out_idx),  32'(e.idx));
                  check_eq("word_last", 32'(out_last), 32'(e.last));
               end
               pend_last = out_last;
            end
         end
      end
   endtask

   // mode: 0 plain, 1 backpressure on word 1, 2 start+done together,
   //       3 start/done poked during STREAM, 4 reset during word 2
   task automatic do_run(input int gap, input logic [BUS_W-1:0] bus, input int mode);
      int    prev = n_dumps;
      int    cnt_exp;
      word_t w;
      cnt_exp = (gap + 1 > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : gap + 1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("busy_after_start", 32'(busy), 1);
      for (int i = 0; i < gap; i++) begin
         @(posedge clk); #1;
      end
      check_eq("valid_in_run", 32'(out_valid), 0);
      res_bus = bus;
      done    = 1'b1;
      start   = (mode == 2);
      for (int k = 0; k < NUM_CH; k++) begin
         w.data = bus[k*WIDTH +: WIDTH];
         w.idx  = IDX_W'(k);
         w.last = (k == N_W - 1);
         sb.push_back(w);
      end
`ifdef RESULT_DUMP_CYCLES_EN
      w.data = WIDTH'(cnt_exp);
      w.idx  = IDX_W'(NUM_CH);
      w.last = 1'b1;
      sb.push_back(w);
`endif
      @(posedge clk); #1;
      done    = 1'b0;
      start   = 1'b0;
      res_bus = '1;
      check_eq("valid_after_done", 32'(out_valid), 1);
      check_eq("busy_in_stream",   32'(busy),      1);
      case (mode)
         1: begin
            @(posedge clk); #1;
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
               check_eq("bp_valid", 32'(out_valid), 1);
               check_eq("bp_data",  32'(out_data),  32'(bus[WIDTH +: WIDTH]));
               check_eq("bp_idx",   32'(out_idx),   1);
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
         3: begin
            @(posedge clk); #1;
            start = 1'b1;
            done  = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            done  = 1'b0;
         end
         4: begin
            repeat (2) @(posedge clk);
            #2 rst_n = 1'b0;
            #1 check_zero_outputs("abort");
            sb.delete();
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (4) @(posedge clk);
            #1 check_eq("no_dump_after_abort", 32'(n_dumps - prev), 0);
            check_zero_outputs("idle_after_abort");
         end
         default: ;
      endcase
      if (mode != 4) begin
         for (int k = 0; k < 100 && n_dumps == prev; k++) @(negedge clk);
         check_eq("dump_count", 32'(n_dumps - prev), 1);
         check_eq("sb_drained", 32'(sb.size()), 0);
         repeat (2) @(posedge clk);
         #1 check_eq("idle_busy", 32'(busy), 0);
         check_eq("idle_valid", 32'(out_valid), 0);
      end
      $display("run gap=%0d mode=%0d cycles_exp=%0d done", gap, mode, cnt_exp);
   endtask

   initial begin
      logic [BUS_W-1:0] bus_a;
      logic [BUS_W-1:0] bus_r;
      bus_a     = {12'hABC, 12'h333, 12'h022, 12'h001};
      rst_n     = 1'b0;
      start     = 1'b0;
      done      = 1'b0;
      res_bus   = '0;
      out_ready = 1'b1;
      fork
         monitor();
      join_none
      repeat (3) @(posedge clk);
      #1 check_zero_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_run(10, bus_a, 0);
      do_run(3,  bus_a, 1);
      do_run(5,  {12'h0F0, 12'h00F, 12'hF00, 12'h5A5}, 2);
      do_run(2,  bus_a, 3);
      do_run(4,  bus_a, 4);
      do_run(10, bus_a, 0);
`ifdef RESULT_DUMP_CYCLES_EN
      do_run(39, bus_a, 0);
`endif
      for (int r = 0; r < 3; r++) begin
         bus_r = {$urandom(), $urandom()};
         do_run(int'($urandom_range(0, 20)), bus_r, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
